// File: rtl/display_arbiter.sv
// display_arbiter: round-robin sharing of the 4-digit display with minimum dwell; DISP_ARB_GAP_EN adds a blank gap between owners
module display_arbiter #(
    parameter int NREQ  = 4,
    parameter int DWELL = 5000000,
    parameter int CW    = 23,
    parameter int GAP   = 1250,
    localparam int OW   = $clog2(NREQ)
) (
    input  logic               clock5,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] val,
    output logic [NREQ-1:0]    grant,
    output logic [OW-1:0]      owner,
    output logic               active,
    output logic               blank,
    output logic [15:0]        dispVal
);
`ifdef DISP_ARB_GAP_EN
    typedef enum logic [1:0] {IDLE, HOLD, GAPS} state_t;
    localparam int GW = $clog2(GAP + 1);
    logic [GW-1:0] gcnt;
`else
    typedef enum logic {IDLE, HOLD} state_t;
    assign blank = 1'b0;
`endif
    state_t        state;
    logic [CW-1:0] cnt;
    logic [OW-1:0] nxt;
    logic          other;
    logic [15:0]   cur;

    // Round-robin search starting after the owner and ending on the owner itself
    always_comb begin
        nxt = owner;
        for (int k = NREQ; k >= 1; k--)
            if (req[(int'(owner) + k) % NREQ]) nxt = OW'((int'(owner) + k) % NREQ);
        other = |(req & ~(NREQ'(1) << owner));
        cur = val[16*int'(owner) +: 16];
    end

    // Grant state machine: idle, holding an owner, and the optional blank gap
    always_ff @(posedge clock5) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= OW'(NREQ - 1);
            active  <= 1'b0;
            dispVal <= 16'h0000;
            cnt     <= '0;
`ifdef DISP_ARB_GAP_EN
            blank   <= 1'b0;
            gcnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= HOLD;
                        grant  <= NREQ'(1) << nxt;
                        owner  <= nxt;
                        active <= 1'b1;
                        cnt    <= '0;
                    end
                end
                HOLD: begin
                    dispVal <= cur;
                    if (!req[owner] || (cnt == CW'(DWELL - 1) && other)) begin
                        cnt <= '0;
                        if (other) begin
`ifdef DISP_ARB_GAP_EN
                            state   <= GAPS;
                            grant   <= '0;
                            active  <= 1'b0;
                            blank   <= 1'b1;
                            dispVal <= 16'h0000;
                            gcnt    <= '0;
`else
                            grant   <= NREQ'(1) << nxt;
                            owner   <= nxt;
`endif
                        end else begin
                            state  <= IDLE;
                            grant  <= '0;
                            active <= 1'b0;
                        end
                    end else begin
                        cnt <= (cnt == CW'(DWELL - 1)) ? '0 : cnt + 1'b1;
                    end
                end
`ifdef DISP_ARB_GAP_EN
                GAPS: begin
                    if (gcnt == GW'(GAP - 1)) begin
                        blank <= 1'b0;
                        if (|req) begin
                            state  <= HOLD;
                            grant  <= NREQ'(1) << nxt;
                            owner  <= nxt;
                            active <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
